// File: rtl/note_lane_scroller_pkg.sv
// Shared types and default geometry for the note lane scroller.
package note_lane_scroller_pkg;

  localparam int LANE_DEPTH_DEF = 16;
  localparam int JUDGE_POS_DEF  = 13;
  localparam int PAT_AW_DEF     = 8;
  localparam int PAT_LEN_DEF    = 200;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ARMED = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/note_lane_scroller_if.sv
// Pattern ROM fetch channel: request/address out, valid/data back.
interface note_lane_scroller_if
  import note_lane_scroller_pkg::*;
#(
  parameter int PAT_AW = PAT_AW_DEF
);
  logic              pat_req;
  logic [PAT_AW-1:0] pat_addr;
  logic              pat_valid;
  logic              pat_data;

  modport master (output pat_req, output pat_addr, input pat_valid, input pat_data);
  modport slave  (input pat_req, input pat_addr, output pat_valid, output pat_data);
endinterface

// File: rtl/note_lane_scroller_lane_hit_finder.sv
// Finds the note closest to the exit inside the judge window and returns a one-hot clear mask.
module lane_hit_finder
  import note_lane_scroller_pkg::*;
#(
  parameter int LANE_DEPTH = LANE_DEPTH_DEF,
  parameter int JUDGE_POS  = JUDGE_POS_DEF
) (
  input  logic [LANE_DEPTH-1:0] lane,
  output logic                  found,
  output logic [LANE_DEPTH-1:0] clr_mask
);

  // Walk from the exit row upward; only the first note seen is selected.
  always_comb begin
    clr_mask = '0;
    found    = 1'b0;
    for (int i = LANE_DEPTH - 1; i >= JUDGE_POS; i--) begin
      clr_mask[i] = lane[i] & ~found;
      found       = found | lane[i];
    end
  end

endmodule

// File: rtl/note_lane_scroller.sv
// Note lane scroller: shifts one lane per tick, fetching rows from a pattern ROM,
// and turns button presses / escaped notes into hit/miss pulses.
module note_lane_scroller
  import note_lane_scroller_pkg::*;
#(
  parameter int LANE_DEPTH = LANE_DEPTH_DEF,
  parameter int JUDGE_POS  = JUDGE_POS_DEF,
  parameter int PAT_AW     = PAT_AW_DEF,
  parameter int PAT_LEN    = PAT_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  btn,
  note_lane_scroller_if.master  pat,
  output logic [LANE_DEPTH-1:0] lane,
  output logic                  hit,
  output logic                  miss,
  output logic                  done,
  output logic                  tick_overrun
);

  // One extra address bit so a full 2**PAT_AW pattern can still reach its end count.
  localparam logic [PAT_AW:0] PAT_END = (PAT_AW + 1)'(PAT_LEN);
  localparam logic [PAT_AW:0] ADDR_ONE = (PAT_AW + 1)'(1);

  state_t                state_r;
  logic [LANE_DEPTH-1:0] lane_r;
  logic [PAT_AW:0]       addr_r;
  logic                  req_r, next_row_r, pend_r, hit_r, miss_r, done_r, ovr_r;

  logic [LANE_DEPTH-1:0] clr_mask_s, cleared_s, shifted_s;
  logic                  found_s, play_s, move_s, judge_s, eff_tick_s, drop_s, xfer_s;
  logic                  pend_next_s;

  lane_hit_finder #(
    .LANE_DEPTH (LANE_DEPTH),
    .JUDGE_POS  (JUDGE_POS)
  ) u_finder (
    .lane     (lane_r),
    .found    (found_s),
    .clr_mask (clr_mask_s)
  );

  assign play_s     = (state_r == S_FETCH) || (state_r == S_ARMED) || (state_r == S_DRAIN);
  assign move_s     = (state_r == S_ARMED) || (state_r == S_DRAIN);
  assign judge_s    = btn && run && play_s;
  assign eff_tick_s = run && move_s && (tick || pend_r);
  assign drop_s     = run && play_s && tick && pend_r;
  assign xfer_s     = req_r && pat.pat_valid;
  // A press is resolved before the shift so a judged bottom note never counts as a miss.
  assign cleared_s  = judge_s ? (lane_r & ~clr_mask_s) : lane_r;
  assign shifted_s  = {cleared_s[LANE_DEPTH-2:0], (state_r == S_ARMED) ? next_row_r : 1'b0};

  // Pending tick: latched while fetching, consumed by the next effective tick.
  always_comb begin
    pend_next_s = pend_r;
    if (run && tick && (state_r == S_FETCH)) begin
      pend_next_s = 1'b1;
    end else if (eff_tick_s) begin
      pend_next_s = 1'b0;
    end else begin
      pend_next_s = pend_r;
    end
  end

  // Main sequencer: state, lane, address counter and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      lane_r     <= '0;
      addr_r     <= '0;
      req_r      <= 1'b0;
      next_row_r <= 1'b0;
      pend_r     <= 1'b0;
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      done_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      hit_r  <= judge_s && found_s;
      miss_r <= eff_tick_s && cleared_s[LANE_DEPTH-1];
      ovr_r  <= ovr_r || drop_s;
      pend_r <= pend_next_s;
      case (state_r)
        S_IDLE: begin
          lane_r <= '0;
          addr_r <= '0;
          done_r <= 1'b0;
          if (run) begin
            state_r <= S_FETCH;
            req_r   <= 1'b1;
          end
        end
        S_FETCH: begin
          lane_r <= cleared_s;
          if (xfer_s) begin
            next_row_r <= pat.pat_data;
            addr_r     <= addr_r + ADDR_ONE;
            req_r      <= 1'b0;
            state_r    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (eff_tick_s) begin
            lane_r <= shifted_s;
            if (addr_r == PAT_END) begin
              state_r <= S_DRAIN;
            end else begin
              state_r <= S_FETCH;
              req_r   <= 1'b1;
            end
          end else begin
            lane_r <= cleared_s;
          end
        end
        S_DRAIN: begin
          if (eff_tick_s) begin
            lane_r <= shifted_s;
            if (shifted_s == '0) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            lane_r <= cleared_s;
          end
        end
        S_DONE: begin
          if (!run) begin
            state_r <= S_IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          req_r   <= 1'b0;
          lane_r  <= '0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign lane         = lane_r;
  assign hit          = hit_r;
  assign miss         = miss_r;
  assign done         = done_r;
  assign tick_overrun = ovr_r;
  assign pat.pat_req  = req_r;
  assign pat.pat_addr = addr_r[PAT_AW-1:0];

endmodule

// File: tb/tb_note_lane_scroller.sv
// Bench for note_lane_scroller: directed scenarios then random play against a row-level lane model.
module tb_note_lane_scroller;

  localparam int LD = 16;
  localparam int JP = 13;
  localparam int PL = 4;

  typedef enum int {P_IDLE, P_FETCH, P_ARMED, P_DRAIN, P_DONE} phase_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0, run = 1'b0, btn = 1'b0;
  logic [LD-1:0] lane;
  logic          hit, miss, done, tick_overrun;

  note_lane_scroller_if #(.PAT_AW(8)) pat ();

  note_lane_scroller #(.LANE_DEPTH(LD), .JUDGE_POS(JP), .PAT_AW(8), .PAT_LEN(PL)) dut (
    .clk (clk), .rst (rst), .tick (tick), .run (run), .btn (btn), .pat (pat),
    .lane (lane), .hit (hit), .miss (miss), .done (done), .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ROM responder state
  bit rom [256];
  int rom_delay = 0;
  int rom_wait  = 0;

  // Reference model: lane as an array of rows, row 0 = entry
  phase_t mp = P_IDLE;
  bit     ml [LD];
  int     m_addr = 0;
  bit     m_next = 1'b0, m_pend = 1'b0;
  bit     e_hit = 1'b0, e_miss = 1'b0, e_done = 1'b0, e_ovr = 1'b0, e_req = 1'b0;
  int     miss_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LD-1:0] model_lane();
    logic [LD-1:0] v;
    v = '0;
    for (int r = 0; r < LD; r++) v[r] = ml[r];
    return v;
  endfunction

  function automatic bit model_empty();
    for (int r = 0; r < LD; r++) if (ml[r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit act;
    e_hit  = 1'b0;
    e_miss = 1'b0;
    if (!rst) begin
      mp = P_IDLE; m_addr = 0; m_pend = 1'b0; m_next = 1'b0;
      e_req = 1'b0; e_done = 1'b0; e_ovr = 1'b0;
      for (int r = 0; r < LD; r++) ml[r] = 1'b0;
      return;
    end
    act = run && (mp == P_FETCH || mp == P_ARMED || mp == P_DRAIN);
    if (act && btn) begin
      for (int r = LD - 1; r >= JP; r--) begin
        if (ml[r]) begin
          ml[r] = 1'b0;
          e_hit = 1'b1;
          break;
        end
      end
    end
    case (mp)
      P_IDLE: begin
        m_addr = 0;
        for (int r = 0; r < LD; r++) ml[r] = 1'b0;
        if (run) begin mp = P_FETCH; e_req = 1'b1; end
      end
      P_FETCH: begin
        if (run && tick) begin
          if (m_pend) e_ovr = 1'b1;
          m_pend = 1'b1;
        end
        if (pat.pat_valid) begin
          m_next = rom[m_addr];
          m_addr++;
          e_req = 1'b0;
          mp = P_ARMED;
        end
      end
      P_ARMED, P_DRAIN: begin
        if (run && (tick || m_pend)) begin
          if (tick && m_pend) e_ovr = 1'b1;
          m_pend = 1'b0;
          e_miss = ml[LD-1];
          for (int r = LD - 1; r > 0; r--) ml[r] = ml[r-1];
          ml[0] = (mp == P_ARMED) ? m_next : 1'b0;
          if (mp == P_ARMED) begin
            if (m_addr == PL) mp = P_DRAIN;
            else begin mp = P_FETCH; e_req = 1'b1; end
          end else if (model_empty()) begin
            mp = P_DONE;
            e_done = 1'b1;
          end
        end
      end
      P_DONE: if (!run) begin mp = P_IDLE; e_done = 1'b0; end
      default: mp = P_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("lane", lane, model_lane());
    chk("hit", hit, e_hit);
    chk("miss", miss, e_miss);
    chk("done", done, e_done);
    chk("tick_overrun", tick_overrun, e_ovr);
    chk("pat_req", pat.pat_req, e_req);
    chk("pat_addr", pat.pat_addr, m_addr[7:0]);
  endtask

  task automatic step(input bit t, input bit r, input bit b);
    bit xfer;
    tick = t; run = r; btn = b;
    pat.pat_valid = 1'b0;
    pat.pat_data  = 1'b0;
    if (rst && pat.pat_req) begin
      if (rom_wait == 0) begin
        pat.pat_valid = 1'b1;
        pat.pat_data  = rom[pat.pat_addr];
      end else begin
        rom_wait--;
      end
    end
    xfer = rst && pat.pat_req && pat.pat_valid;
    model_step();
    @(posedge clk);
    #1;
    if (xfer || !rst) rom_wait = rom_delay;
    if (miss) miss_seen++;
    check_all();
  endtask

  task automatic tick_group(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic set_rom(input bit a, input bit b, input bit c, input bit d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    pat.pat_valid = 1'b0;
    pat.pat_data  = 1'b0;
    for (int r = 0; r < LD; r++) ml[r] = 1'b0;

    // reset
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_lane", lane, 32'h0);
    chk("rst_req", pat.pat_req, 32'h0);
    rst = 1'b1;

    // 1: pattern 1,0,1,1 enters the lane, then every note escapes as a miss
    set_rom(1'b1, 1'b0, 1'b1, 1'b1);
    rom_delay = 0; rom_wait = 0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    tick_group(4);
    chk("t1_lane4", lane, 32'h000b);
    miss_seen = 0;
    tick_group(16);
    chk("t1_misses", miss_seen, 32'd3);
    chk("t1_done", done, 32'h1);

    // 2: press on the tick that moves the bottom note out -> hit, not miss
    step(1'b0, 1'b0, 1'b0);
    set_rom(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    tick_group(16);
    chk("t2_bottom", lane, 32'h8000);
    step(1'b1, 1'b1, 1'b1);
    chk("t2_hit", hit, 32'h1);
    chk("t2_miss", miss, 32'h0);
    chk("t2_lane", lane, 32'h0);

    // 3: press with nothing in the judge window
    step(1'b0, 1'b0, 1'b0);
    set_rom(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    tick_group(4);
    step(1'b0, 1'b1, 1'b1);
    chk("t3_hit", hit, 32'h0);
    chk("t3_lane", lane, 32'h000f);

    // 5: paused with ticks and a press -> frozen, nothing pended
    for (int i = 0; i < 10; i++) step((i % 3 == 0) && (i < 9), 1'b0, i == 5);
    chk("t5_frozen", lane, 32'h000f);
    chk("t5_ovr", tick_overrun, 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_no_pend", lane, 32'h000f);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_resume", lane, 32'h001e);
    for (int i = 0; i < 20 && !e_done; i++) tick_group(1);
    chk("t5_done", done, 32'h1);

    // 4: slow ROM; one tick while fetching is pended, two overrun
    step(1'b0, 1'b0, 1'b0);
    set_rom(1'b1, 1'b0, 1'b0, 1'b0);
    rom_delay = 5; rom_wait = 5;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12 && mp != P_ARMED; i++) step(1'b0, 1'b1, 1'b0);
    chk("t4_armed_req", pat.pat_req, 32'h0);
    chk("t4_pre_shift", lane, 32'h0);
    step(1'b0, 1'b1, 1'b0);
    chk("t4_pend_shift", lane, 32'h0001);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_overrun", tick_overrun, 32'h1);

    // 6: reset while a fetch is outstanding
    chk("t6_req_up", pat.pat_req, 32'h1);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    chk("t6_lane", lane, 32'h0);
    chk("t6_req", pat.pat_req, 32'h0);
    chk("t6_ovr", tick_overrun, 32'h0);
    chk("t6_addr", pat.pat_addr, 32'h0);
    rst = 1'b1;

    // random play
    for (int i = 0; i < 3000; i++) begin
      bit t, r, b;
      if (mp == P_IDLE) for (int k = 0; k < PL; k++) rom[k] = 1'($urandom % 2);
      if (pat.pat_req == 1'b0) rom_delay = int'($urandom_range(0, 3));
      t = ($urandom % 5) == 0;
      b = ($urandom % 6) == 0;
      r = (mp == P_DONE) ? (($urandom % 2) == 0) : (($urandom % 20) != 0);
      if (($urandom % 700) == 0) rst = 1'b0;
      step(t, r, b);
      rst = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
